morph_bin_3x3: RTL
==================

// Module: morph_bin_3x3
// PURPOSE
//  Binary morphology stage directly downstream of the 3x3 Sobel edge stage. Consumes the binary edge
//  stream (8'hff/8'h00) and applies a 3x3 dilation (close edge gaps) or erosion (remove speckle).
//  Holds two 1-bit line buffers and row/column counters with zero-delay border padding; output keeps
//  the de/hsync/vsync streaming format so it drops into the VGA/LCD display path unchanged.
// PARAMETERS
//  H_DISP     12'd640  active pixels per line (line-buffer depth)
//  V_DISP     12'd480  active lines per frame (row counter saturation limit)
//  MODE       1'b0     0 = dilation (window OR, pad 0), 1 = erosion (window AND, pad 1)
//  LATENCY    3        fixed pipeline depth in clk cycles; not user-tunable, documents the delay chain
// PORTS
//  clk           in   1  pixel clock
//  rst_n         in   1  asynchronous active-low reset
//  sobel_de      in   1  input data enable (active pixel)
//  sobel_hsync   in   1  input line sync
//  sobel_vsync   in   1  input frame sync, active high; rising edge = frame start
//  sobel_data    in   8  input pixel; bit = |sobel_data (any nonzero = 1)
//  morph_de      out  1  sobel_de delayed LATENCY cycles
//  morph_hsync   out  1  sobel_hsync delayed LATENCY cycles
//  morph_vsync   out  1  sobel_vsync delayed LATENCY cycles
//  morph_data    out  8  8'hff if result bit = 1, else 8'h00; forced 8'h00 when morph_de = 0
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, window and line-buffer valid flags cleared; RAM contents not reset.
//  - col_cnt: +1 per cycle with sobel_de=1; cleared on de falling edge; saturates at H_DISP-1.
//  - row_cnt: +1 on each de falling edge; cleared on vsync rising edge; saturates at V_DISP-1.
//  - Line buffers lb1 (row y-1), lb2 (row y-2), 1 bit x H_DISP each, addressed by col_cnt. On de:
//    read lb1[c], lb2[c]; write lb2[c] <= lb1[c], lb1[c] <= bit (read-before-write, same cycle).
//  - Pixels past H_DISP in a line: not written; their above-row taps replaced by pad value.
//  - Window for input pixel (y,x): rows y-2..y, cols x-2..x. Out-of-image taps (y-k<0, x-k<0)
//    are replaced by pad (MODE 0: 0, MODE 1: 1). Row validity: lb1 tap valid when row_cnt>=1, lb2 when >=2;
//    column validity: tap valid when col_cnt>=k. No horizontal wrap between lines, no vertical carry
//    across frames (vsync rising edge clears row_cnt, so new frame's rows 0/1 are padded).
//  - Resulting spatial offset is (+1 row, +1 col) relative to window centre; this is the codebase's
//    fixed convention and downstream consumers accept it.
//  - Pipeline: clk1 register bit, lb taps, validity flags; clk2 shift 3-column window registers
//    (columns cleared to pad at line start); clk3 OR (MODE 0) / AND (MODE 1) of 9 taps -> morph_data.
//  - Sync: de/hsync/vsync each pass through a LATENCY-deep shift register; output data aligned to morph_de.
//  - Reset asserted mid-frame: outputs drop to 0 immediately (async); after release, output is
//    well-formed from the next pixel; rows before the next vsync rising edge are treated as top rows.
//  - Simultaneous de falling edge and vsync rising edge: vsync wins, row_cnt = 0.
// TESTING
//  1. 640x480 black frame, single white pixel at (10,10), MODE=0 -> morph_data=ff exactly at
//     output coords rows 10..12, cols 10..12; all other pixels 00.
//  2. All-white frame, single black pixel at (10,10), MODE=1 -> 00 exactly at rows 10..12, cols
//     10..12; all others ff (border stays ff because pad=1).
//  3. Random de/hsync/vsync patterns -> morph_de/hsync/vsync equal inputs delayed exactly 3 clocks;
//     morph_data=00 whenever morph_de=0.
//  4. White pixel at (5,639), MODE=0 -> ff at (5..7,639) only; (6,0),(7,0) stay 00 (no wrap).
//  5. Frame N last row all white, frame N+1 all black, MODE=0 -> frame N+1 output entirely 00.
//  6. rst_n pulsed low mid-line 100 -> all outputs 0 same cycle; next frame output matches scenario 1.

Source files
------------

// File: rtl/morph_bin_3x3_if.sv
// Binary video stream bundle (data enable, syncs, 8-bit pixel) shared by the
// edge stage input and the morphology output.
interface morph_bin_3x3_if;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [7:0] data;

    modport master (output de, hsync, vsync, data);
    modport slave  (input  de, hsync, vsync, data);
endinterface

// File: rtl/morph_bin_3x3.sv
// 3x3 binary dilation (MODE 0) / erosion (MODE 1) on the Sobel edge stream,
// using two 1-bit line buffers and a fixed 3-cycle de/hsync/vsync-aligned pipeline.
module morph_bin_3x3 #(
    parameter logic [11:0] H_DISP = 12'd640,
    parameter logic [11:0] V_DISP = 12'd480,
    parameter logic        MODE   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    morph_bin_3x3_if.slave  sobel_i,
    morph_bin_3x3_if.master morph_o
);
    localparam int          LATENCY = 3;
    localparam int          HD      = int'(H_DISP);
    localparam int          AW      = (HD > 1) ? $clog2(HD) : 1;
    localparam logic [11:0] H_LAST  = H_DISP - 12'd1;
    localparam logic [11:0] V_LAST  = V_DISP - 12'd1;
    localparam logic        PAD     = MODE;

    logic            de_prev_q;
    logic            vs_prev_q;
    logic            de_fall;
    logic            vs_rise;

    logic [11:0]     col_cnt_q, col_cnt_d;
    logic            col_ovf_q, col_ovf_d;
    logic [11:0]     row_cnt_q, row_cnt_d;
    logic            frame_ok_q, frame_ok_d;

    logic            lb1_mem [HD];
    logic            lb2_mem [HD];
    logic [AW-1:0]   lb_addr;
    logic            lb1_rd;
    logic            lb2_rd;
    logic            pix_bit;
    logic            in_range;

    logic            s1_bit_q, s1_bit_d;
    logic            s1_top1_q, s1_top1_d;
    logic            s1_top2_q, s1_top2_d;
    logic            s1_first_q, s1_first_d;

    logic [2:0][2:0] win_q, win_d;
    logic            win_hit;
    logic [7:0]      data_q, data_d;

    logic [LATENCY-1:0] de_pipe_q;
    logic [LATENCY-1:0] hs_pipe_q;
    logic [LATENCY-1:0] vs_pipe_q;

    assign de_fall  = de_prev_q & ~sobel_i.de;
    assign vs_rise  = sobel_i.vsync & ~vs_prev_q;
    assign pix_bit  = |sobel_i.data;
    assign in_range = ~col_ovf_q;
    assign lb_addr  = col_cnt_q[AW-1:0];
    assign lb1_rd   = lb1_mem[lb_addr];
    assign lb2_rd   = lb2_mem[lb_addr];

    // col_ovf marks pixels beyond the line-buffer depth once col_cnt has saturated
    always_comb begin
        col_cnt_d  = col_cnt_q;
        col_ovf_d  = col_ovf_q;
        row_cnt_d  = row_cnt_q;
        frame_ok_d = frame_ok_q;
        if (sobel_i.de) begin
            if (col_cnt_q == H_LAST) begin
                col_ovf_d = 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 12'd1;
            end
        end else if (de_fall) begin
            col_cnt_d = 12'd0;
            col_ovf_d = 1'b0;
        end
        if (de_fall && (row_cnt_q != V_LAST)) begin
            row_cnt_d = row_cnt_q + 12'd1;
        end
        if (vs_rise) begin
            row_cnt_d  = 12'd0;
            frame_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            col_cnt_q  <= 12'd0;
            col_ovf_q  <= 1'b0;
            row_cnt_q  <= 12'd0;
            frame_ok_q <= 1'b0;
        end else begin
            de_prev_q  <= sobel_i.de;
            vs_prev_q  <= sobel_i.vsync;
            col_cnt_q  <= col_cnt_d;
            col_ovf_q  <= col_ovf_d;
            row_cnt_q  <= row_cnt_d;
            frame_ok_q <= frame_ok_d;
        end
    end

    // Line buffer RAM: read-before-write, contents intentionally not reset
    always_ff @(posedge clk) begin
        if (sobel_i.de && in_range) begin
            lb1_mem[lb_addr] <= pix_bit;
            lb2_mem[lb_addr] <= lb1_rd;
        end
    end

    // frame_ok keeps rows after a mid-frame reset padded until the next frame start
    always_comb begin
        s1_bit_d   = pix_bit;
        s1_top1_d  = (in_range && frame_ok_q && (row_cnt_q >= 12'd1)) ? lb1_rd : PAD;
        s1_top2_d  = (in_range && frame_ok_q && (row_cnt_q >= 12'd2)) ? lb2_rd : PAD;
        s1_first_d = (col_cnt_q == 12'd0) && !col_ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_bit_q   <= 1'b0;
            s1_top1_q  <= PAD;
            s1_top2_q  <= PAD;
            s1_first_q <= 1'b0;
        end else begin
            s1_bit_q   <= s1_bit_d;
            s1_top1_q  <= s1_top1_d;
            s1_top2_q  <= s1_top2_d;
            s1_first_q <= s1_first_d;
        end
    end

    // Column 0 is the newest; older columns are flushed to pad at line start
    always_comb begin
        win_d = win_q;
        if (de_pipe_q[0]) begin
            win_d[0] = {s1_top2_q, s1_top1_q, s1_bit_q};
            win_d[1] = s1_first_q ? {3{PAD}} : win_q[0];
            win_d[2] = s1_first_q ? {3{PAD}} : win_q[1];
        end
    end

    always_comb begin
        win_hit = MODE ? (&win_q) : (|win_q);
        data_d  = (de_pipe_q[1] && win_hit) ? 8'hff : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= {9{PAD}};
            data_q <= 8'h00;
        end else begin
            win_q  <= win_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_pipe_q <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
        end else begin
            de_pipe_q <= {de_pipe_q[LATENCY-2:0], sobel_i.de};
            hs_pipe_q <= {hs_pipe_q[LATENCY-2:0], sobel_i.hsync};
            vs_pipe_q <= {vs_pipe_q[LATENCY-2:0], sobel_i.vsync};
        end
    end

    assign morph_o.de    = de_pipe_q[LATENCY-1];
    assign morph_o.hsync = hs_pipe_q[LATENCY-1];
    assign morph_o.vsync = vs_pipe_q[LATENCY-1];
    assign morph_o.data  = data_q;
endmodule
